// File: rtl/axis_nn_pkg.sv
// Shared types and result-word layout for the AXIS NN classification stages.
package axis_nn_pkg;

    localparam int SCORE_W       = 16;
    localparam int RES_SCORE_MSB = 63;
    localparam int RES_IDX_LSB   = 40;
    localparam int RES_ERR_BIT   = 32;
    localparam int RES_CNT_LSB   = 16;

    localparam logic [15:0] SAT16 = 16'hFFFF;

    typedef logic signed [SCORE_W-1:0] score_t;

    localparam score_t SCORE_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // best >= second always holds, so the difference is never negative.
    function automatic logic [15:0] margin_sat(input score_t best, input score_t second);
        logic signed [17:0] diff;
        diff = signed'({{2{best[SCORE_W-1]}}, best}) - signed'({{2{second[SCORE_W-1]}}, second});
        return (diff > 18'sd65535) ? SAT16 : diff[15:0];
    endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational running-argmax step: folds one indexed score into {best, best_idx, second}.
module argmax_update
    import axis_nn_pkg::*;
(
    input  score_t      cur_best,
    input  score_t      cur_second,
    input  logic [7:0]  cur_idx,
    input  score_t      score,
    input  logic [7:0]  idx,
    output score_t      new_best,
    output score_t      new_second,
    output logic [7:0]  new_idx
);

    // Strict compares: on a tie the earlier (lower) index keeps the lead.
    always_comb begin
        new_best   = cur_best;
        new_second = cur_second;
        new_idx    = cur_idx;
        if (score > cur_best) begin
            new_second = cur_best;
            new_best   = score;
            new_idx    = idx;
        end else if (score > cur_second) begin
            new_second = score;
        end
    end

endmodule

// File: rtl/axis_class_argmax.sv
// Packet-level argmax over signed class scores on AXI-Stream; one 64-bit result beat per packet.
// Define ARGMAX_PKT_COUNT_EN to carry a running result count in result[31:16].
module axis_class_argmax
    import axis_nn_pkg::*;
#(
    parameter int NUM_CLASS = 4,
    parameter int SCORE_LSB = 48
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast
);

    localparam logic [7:0] NUM_C = 8'(NUM_CLASS);

    // state | meaning
    // IDLE  | waiting for first score beat of a packet
    // ACC   | folding further score beats into the running argmax
    // EMIT  | result held on m_axis until accepted
    state_t state, state_nxt;

    logic       rdy_en;
    logic [7:0] idx_cnt;
    logic [7:0] best_idx;
    score_t     best, second;
    logic       err;

    logic       beat, res_acc, in_range, fin_err;
    score_t     score, ub_best, ub_second, fin_best, fin_second, nb_best, nb_second;
    logic [7:0] ub_idx, upd_idx, nb_idx, fin_idx, fin_cnt;
    logic [15:0] pkt_cnt;
    logic [63:0] result;
    logic        unused_tdata;

    assign beat         = s_axis_tvalid && s_axis_tready;
    assign res_acc      = m_axis_tvalid && m_axis_tready;
    assign score        = s_axis_tdata[SCORE_LSB +: SCORE_W];
    assign unused_tdata = ^s_axis_tdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (beat) state_nxt = s_axis_tlast ? EMIT : ACC;
            ACC:     if (beat && s_axis_tlast) state_nxt = EMIT;
            EMIT:    if (m_axis_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = rdy_en && (state != EMIT);
        m_axis_tvalid = (state == EMIT);
        m_axis_tlast  = (state == EMIT);
    end

    // The first beat of a packet starts from an empty ranking rather than stale registers.
    always_comb begin
        if (state == IDLE) begin
            ub_best   = SCORE_MIN;
            ub_second = SCORE_MIN;
            ub_idx    = 8'd0;
            upd_idx   = 8'd0;
        end else begin
            ub_best   = best;
            ub_second = second;
            ub_idx    = best_idx;
            upd_idx   = idx_cnt;
        end
    end

    argmax_update u_update (
        .cur_best   (ub_best),
        .cur_second (ub_second),
        .cur_idx    (ub_idx),
        .score      (score),
        .idx        (upd_idx),
        .new_best   (nb_best),
        .new_second (nb_second),
        .new_idx    (nb_idx)
    );

    assign in_range   = (state == IDLE) || (idx_cnt < NUM_C);
    assign fin_best   = in_range ? nb_best   : best;
    assign fin_second = in_range ? nb_second : second;
    assign fin_idx    = in_range ? nb_idx    : best_idx;
    assign fin_cnt    = in_range ? upd_idx + 8'd1 : idx_cnt;
    assign fin_err    = ((state != IDLE) && err) || !in_range
                        || (s_axis_tlast && (fin_cnt < NUM_C));

    always_comb begin
        result                                  = '0;
        result[RES_SCORE_MSB -: SCORE_W]        = fin_best;
        result[RES_IDX_LSB +: 8]                = fin_idx;
        result[RES_ERR_BIT]                     = fin_err;
        result[RES_CNT_LSB +: 16]               = pkt_cnt;
        result[15:0]                            = margin_sat(fin_best, fin_second);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_en       <= 1'b0;
            idx_cnt      <= '0;
            best         <= SCORE_MIN;
            second       <= SCORE_MIN;
            best_idx     <= '0;
            err          <= 1'b0;
            m_axis_tdata <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (beat) begin
                best     <= fin_best;
                second   <= fin_second;
                best_idx <= fin_idx;
                idx_cnt  <= fin_cnt;
                err      <= fin_err;
                if (s_axis_tlast) m_axis_tdata <= result;
            end
        end
    end

`ifdef ARGMAX_PKT_COUNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)     pkt_cnt <= '0;
        else if (res_acc) pkt_cnt <= pkt_cnt + 16'd1;
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule
